// File: rtl/otter_hazard_ctrl_pkg.sv
// rtl/otter_hazard_ctrl_pkg.sv - shared types for the OTTER hazard controller
package otter_pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL_LU = 2'd1,
    WAIT_MEM = 2'd2
  } hz_state_t;

  // Shadow copy of the register-related fields of one pipeline stage
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rd_wr;
    logic       is_load;
    logic       valid;
  } hz_stage_t;

  localparam hz_stage_t NOP_STAGE = '{
    rs1: 5'd0, rs2: 5'd0, rd: 5'd0, rd_wr: 1'b0, is_load: 1'b0, valid: 1'b0
  };

  // MEM wins over WB because it holds the younger result
  function automatic fwd_sel_t fwd_pick(hz_stage_t mem_s, hz_stage_t wb_s, logic [4:0] rs);
    if (mem_s.rd_wr && (mem_s.rd == rs)) return FWD_MEM;
    if (wb_s.rd_wr && (wb_s.rd == rs))   return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/otter_hazard_ctrl_if.sv
// rtl/otter_hazard_ctrl_if.sv - pipeline <-> hazard controller signal bundle
interface otter_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic             de_valid;
  logic [4:0]       de_rs1_addr;
  logic [4:0]       de_rs2_addr;
  logic             de_rs1_used;
  logic             de_rs2_used;
  logic [4:0]       de_rd_addr;
  logic             de_reg_write;
  logic             de_is_load;
  logic             ex_redirect;
  logic             mem_busy;
  logic             pc_write;
  logic             if_de_write;
  logic             if_de_flush;
  logic             de_ex_bubble;
  logic             ex_mem_write;
  logic             mem_wb_write;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output de_valid, de_rs1_addr, de_rs2_addr, de_rs1_used, de_rs2_used,
           de_rd_addr, de_reg_write, de_is_load, ex_redirect, mem_busy,
    input  pc_write, if_de_write, if_de_flush, de_ex_bubble, ex_mem_write,
           mem_wb_write, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );

  modport slave (
    input  de_valid, de_rs1_addr, de_rs2_addr, de_rs1_used, de_rs2_used,
           de_rd_addr, de_reg_write, de_is_load, ex_redirect, mem_busy,
    output pc_write, if_de_write, if_de_flush, de_ex_bubble, ex_mem_write,
           mem_wb_write, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/otter_hazard_ctrl_fwd.sv
// rtl/otter_hazard_ctrl_fwd.sv - EX operand forwarding select logic
module otter_fwd_unit
  import otter_pipe_pkg::*;
(
  input  hz_stage_t ex_stage,
  input  hz_stage_t mem_stage,
  input  hz_stage_t wb_stage,
  output fwd_sel_t  fwd_a_sel,
  output fwd_sel_t  fwd_b_sel
);

  // Pick the youngest in-flight producer of each EX source register
  always_comb begin
    fwd_a_sel = fwd_pick(mem_stage, wb_stage, ex_stage.rs1);
    fwd_b_sel = fwd_pick(mem_stage, wb_stage, ex_stage.rs2);
  end

endmodule

// File: rtl/otter_hazard_ctrl.sv
// rtl/otter_hazard_ctrl.sv - load-use stall, redirect flush and memory freeze control
module otter_hazard_ctrl
  import otter_pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic                CLK,
  input logic                RESET_N,
  otter_hazard_ctrl_if.slave hz
);

  hz_stage_t        ex_q, mem_q, wb_q, de_rec;
  hz_state_t        state_q, state_d;
  fwd_sel_t         fwd_a, fwd_b;
  logic             load_use;
  logic             pc_write, if_de_write, if_de_flush, de_ex_bubble;
  logic             ex_mem_write, mem_wb_write;
  logic [CNT_W-1:0] stall_q, flush_q;

  // Build the record DE would hand to EX; writes to x0 never count
  always_comb begin
    de_rec         = NOP_STAGE;
    de_rec.rs1     = hz.de_rs1_addr;
    de_rec.rs2     = hz.de_rs2_addr;
    de_rec.rd      = hz.de_rd_addr;
    de_rec.rd_wr   = hz.de_reg_write && (hz.de_rd_addr != 5'd0);
    de_rec.is_load = hz.de_is_load;
    de_rec.valid   = hz.de_valid;
  end

  // A load in EX feeding a source that DE actually reads
  always_comb begin
    load_use = ex_q.is_load && ex_q.rd_wr && hz.de_valid &&
               ((hz.de_rs1_used && (ex_q.rd == hz.de_rs1_addr)) ||
                (hz.de_rs2_used && (ex_q.rd == hz.de_rs2_addr)));
  end

  // Shadow pipeline advances unless memory freezes everything
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ex_q  <= NOP_STAGE;
      mem_q <= NOP_STAGE;
      wb_q  <= NOP_STAGE;
    end else if (!hz.mem_busy) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= de_ex_bubble ? NOP_STAGE : de_rec;
    end
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= RUN;
    else          state_q <= state_d;
  end

  // FSM next state; a wrong-path load-use under redirect does not stall
  always_comb begin
    state_d = RUN;
    if (hz.mem_busy) begin
      state_d = WAIT_MEM;
    end else begin
      case (state_q)
        RUN:      state_d = (!hz.ex_redirect && load_use) ? STALL_LU : RUN;
        STALL_LU: state_d = RUN;
        WAIT_MEM: state_d = RUN;
        default:  state_d = RUN;
      endcase
    end
  end

  // Enables/flush/bubble by event priority: reset > busy > redirect > load-use
  always_comb begin
    pc_write     = 1'b1;
    if_de_write  = 1'b1;
    ex_mem_write = 1'b1;
    mem_wb_write = 1'b1;
    if_de_flush  = 1'b0;
    de_ex_bubble = 1'b0;
    if (RESET_N) begin
      if (hz.mem_busy) begin
        pc_write     = 1'b0;
        if_de_write  = 1'b0;
        ex_mem_write = 1'b0;
        mem_wb_write = 1'b0;
      end else if (hz.ex_redirect) begin
        if_de_flush  = 1'b1;
        de_ex_bubble = 1'b1;
      end else if (load_use) begin
        pc_write     = 1'b0;
        if_de_write  = 1'b0;
        de_ex_bubble = 1'b1;
      end
    end
  end

  // Saturating performance counters
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_write && (stall_q != '1))  stall_q <= stall_q + CNT_W'(1);
      if (if_de_flush && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  otter_fwd_unit u_fwd (
    .ex_stage  (ex_q),
    .mem_stage (mem_q),
    .wb_stage  (wb_q),
    .fwd_a_sel (fwd_a),
    .fwd_b_sel (fwd_b)
  );

  assign hz.pc_write     = pc_write;
  assign hz.if_de_write  = if_de_write;
  assign hz.if_de_flush  = if_de_flush;
  assign hz.de_ex_bubble = de_ex_bubble;
  assign hz.ex_mem_write = ex_mem_write;
  assign hz.mem_wb_write = mem_wb_write;
  assign hz.fwd_a_sel    = fwd_a;
  assign hz.fwd_b_sel    = fwd_b;
  assign hz.stall_cnt    = stall_q;
  assign hz.flush_cnt    = flush_q;

endmodule
